multi_busy_control: RTL

- Parametrised successor to the single-path busy logic. Counts accepted triggers and compares them with the read counts of N_CH readout channels (e.g. two OFC-II boards).
- Drives a hysteretic busy to the trigger system. Detects read-ahead faults per channel and latches them.
- Keeps dead-time and lost-trigger statistics.
- Sits between the trigger/live interface and the readout-channel event counters.

---
 rtl/multi_busy_control.sv | 137 +++++++++++++
 1 files changed

// File: rtl/multi_busy_control.sv
// Busy controller for N_CH readout channels: compares the accepted trigger count with
// per-channel read counts, drives a hysteretic busy, latches read-ahead faults, keeps stats.

module multi_busy_lane #(
  parameter int CNT_W = 16
) (
  input  logic [CNT_W-1:0] n_trig_i,
  input  logic [CNT_W-1:0] n_read_i,
  input  logic             en_i,
  input  logic             ovf_i,
  output logic [CNT_W-1:0] d_o,
  output logic             ovf_d_o,
  output logic             qual_o
);
  logic [CNT_W-1:0] r;
  logic             hit;

  assign d_o = n_trig_i - n_read_i;
  assign r   = n_read_i - n_trig_i;
  // Reading ahead by less than half the counter range is a fault; more is just a lag that wrapped.
  assign hit     = en_i && (r != '0) && !r[CNT_W-1];
  assign ovf_d_o = ovf_i | hit;
  // A channel faulting this cycle is already excluded, so its bogus distance never reaches occupancy.
  assign qual_o  = en_i && !ovf_d_o;
endmodule

module multi_busy_control #(
  parameter int N_CH    = 2,
  parameter int CNT_W   = 16,
  parameter int DEPTH_W = 5,
  parameter int STAT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  live_rising,
  input  logic                  trig,
  input  logic [N_CH*CNT_W-1:0] n_read,
  input  logic [N_CH-1:0]       ch_enable,
  input  logic [DEPTH_W-1:0]    max_nevent,
  input  logic                  force_busy,
  output logic                  busy,
  output logic [N_CH-1:0]       read_overflow,
  output logic [CNT_W-1:0]      n_trig,
  output logic [CNT_W-1:0]      occupancy,
  output logic [STAT_W-1:0]     trig_lost,
  output logic [STAT_W-1:0]     busy_cycles
);
  localparam int XW = ((CNT_W > DEPTH_W) ? CNT_W : DEPTH_W) + 1;

  typedef enum logic [1:0] {RUN_OK, RUN_BUSY, FAULT} state_e;

  state_e                       state_q, state_d;
  logic                         busy_q;
  logic [N_CH-1:0]              ovf_q;
  logic [CNT_W-1:0]             n_trig_q, occ_q, occ_d;
  logic [STAT_W-1:0]            lost_q, bcyc_q;

  logic [N_CH-1:0][CNT_W-1:0]   d;
  logic [N_CH-1:0]              ovf_d, qual;
  logic [XW-1:0]                occ_x, m_x;
  logic                         assert_c, release_c;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    multi_busy_lane #(.CNT_W(CNT_W)) u_lane (
      .n_trig_i (n_trig_q),
      .n_read_i (n_read[g*CNT_W +: CNT_W]),
      .en_i     (ch_enable[g]),
      .ovf_i    (ovf_q[g]),
      .d_o      (d[g]),
      .ovf_d_o  (ovf_d[g]),
      .qual_o   (qual[g])
    );
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < N_CH; k++)
      if (qual[k] && (d[k] > occ_d)) occ_d = d[k];
  end

  // Thresholds use added offsets so small M never underflows.
  assign occ_x     = XW'(occ_q);
  assign m_x       = XW'(max_nevent);
  assign assert_c  = (m_x == '0) || ((occ_x + XW'(1)) >= m_x);
  assign release_c = (m_x >= XW'(3)) && ((occ_x + XW'(3)) <= m_x);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN_OK: begin
        if (|ovf_q)                       state_d = FAULT;
        else if (assert_c || force_busy)  state_d = RUN_BUSY;
      end
      RUN_BUSY: begin
        if (|ovf_q)                          state_d = FAULT;
        else if (release_c && !force_busy)   state_d = RUN_OK;
      end
      FAULT:   state_d = FAULT;
      default: state_d = RUN_OK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN_OK;
      busy_q   <= 1'b0;
      ovf_q    <= '0;
      n_trig_q <= '0;
      occ_q    <= '0;
      lost_q   <= '0;
      bcyc_q   <= '0;
    end else if (live_rising) begin
      state_q  <= RUN_OK;
      busy_q   <= 1'b0;
      ovf_q    <= '0;
      n_trig_q <= '0;
      occ_q    <= '0;
      lost_q   <= '0;
      bcyc_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != RUN_OK);
      ovf_q   <= ovf_d;
      occ_q   <= occ_d;
      if (trig) n_trig_q <= n_trig_q + CNT_W'(1);
      if (trig && busy_q && (lost_q != '1)) lost_q <= lost_q + STAT_W'(1);
      if (busy_q && (bcyc_q != '1))         bcyc_q <= bcyc_q + STAT_W'(1);
    end
  end

  assign busy          = busy_q;
  assign read_overflow = ovf_q;
  assign n_trig        = n_trig_q;
  assign occupancy     = occ_q;
  assign trig_lost     = lost_q;
  assign busy_cycles   = bcyc_q;
endmodule
